log_antilog_mac_seq: RTL and testbench
======================================

Name: log_antilog_mac_seq

Overview:
- Downstream consumer of the log-domain functional-link expansion stage.
- Takes one frame of Q_ORD log-magnitude terms (Q5.12, with sign and valid bits) and a matching frame of log-domain weights.
- Forms each product by log addition followed by a Mitchell antilog, then accumulates the Q_ORD signed products sequentially, one term per cycle.
- Returns the saturated linear filter output y in Q(QP) under a valid/ready handshake.

Parameters:
- Q_ORD, 7, number of expansion terms per frame.
- WIDTH, 16, output word width (signed).
- QP, 12, fractional bits of the output and of the log fraction field.
- LOG_WIDTH, 17, width of each log word (signed Q5.12).
- ACC_WIDTH, 32, accumulator width (signed).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  frame present on inputs.
- in_ready  out  1  block can accept a frame.
- phi_log_packed  in  Q_ORD*LOG_WIDTH  term i log2|phi_i| at [LOG_WIDTH*i +: LOG_WIDTH].
- phi_sign_packed  in  Q_ORD  sign of phi_i (1 = negative).
- phi_valid_packed  in  Q_ORD  0 = phi_i is exactly zero; the log word is ignored.
- w_log_packed  in  Q_ORD*LOG_WIDTH  log2|w_i|, same packing and format.
- w_sign_packed  in  Q_ORD  sign of w_i.
- w_valid_packed  in  Q_ORD  0 = w_i is zero.
- y_out  out  WIDTH  signed result, Q(QP).
- out_valid  out  1  y_out valid.
- out_ready  in  1  consumer accepts y_out.

Behaviour:
- Reset (reset==0 at an edge): state=IDLE, cnt=0, acc=0, y_out=0, out_valid=0; the internal frame registers are cleared. Reset mid-frame abandons the frame, and no output is produced for it.
- in_ready = (state==IDLE). out_valid = (state==DONE).
- The FSM has three states: IDLE, ACC and DONE.
- IDLE: on in_valid && in_ready, latch all six input vectors, set acc=0 and cnt=0, and go to ACC. Inputs may change freely after acceptance.
- ACC: each cycle, process term cnt as follows.
  - s = phi_log[cnt] + w_log[cnt], signed, LOG_WIDTH+1 bits.
  - e = s >>> QP (arithmetic shift); f = s[QP-1:0]; m = 2^QP + f (Mitchell mantissa 1.f, Q(QP)).
  - mag: if e>=0, mag = m << e, saturated to 2^(ACC_WIDTH-1)-1 when the result exceeds it. If e<0, mag = m >> (-e), truncating; mag = 0 when -e > QP.
  - mag is forced to 0 when phi_valid[cnt]==0 or w_valid[cnt]==0.
  - term = (phi_sign[cnt] XOR w_sign[cnt]) ? -mag : mag.
  - acc_next = acc + term, saturated to the signed ACC_WIDTH range. acc <= acc_next and cnt <= cnt+1.
  - When cnt==Q_ORD-1: y_out <= acc_next saturated to the signed WIDTH range (max 2^(WIDTH-1)-1, min -2^(WIDTH-1)), cnt <= 0, and go to DONE.
- DONE: hold y_out stable. On out_ready, go to IDLE; out_valid drops on the next cycle. in_valid is ignored while not in IDLE.
- Latency: out_valid rises exactly Q_ORD clock edges after the accepting edge.
- Minimum frame period is Q_ORD+2 cycles (accept, Q_ORD-1 further ACC cycles, DONE, IDLE).
- y_out keeps its last value after the handshake until the next frame completes.
- Arithmetic is two's complement throughout; no rounding beyond the stated truncation.

Test Plan:
- All phi_log=0, w_log=0, all signs 0, all valids 1 -> y_out=28672 (7.0), with out_valid exactly 7 edges after acceptance.
- Same as above with phi_sign[i]=i[0] -> y_out=4096 (4 positive terms minus 3 negative terms = 1.0).
- Only term 0 valid: phi_log=-4096 gives y_out=2048; repeating with phi_log=+2048 gives y_out=6144 (Mitchell 1.5); w_valid=0 on term 0 gives y_out=0.
- All phi_log=8192 with w_log=0 (each term 4.0, sum 28.0) -> y_out=32767; with all phi_sign=1 -> y_out=-32768.
- Hold out_ready=0 for 5 cycles in DONE -> y_out stable, in_ready=0, and a frame presented on in_valid is not accepted. Raise out_ready -> the new frame is accepted in the following IDLE cycle.
- Assert reset=0 for one edge mid-ACC (cnt=3) -> out_valid=0, y_out=0, in_ready=1 on the next cycle; a fresh frame then yields the correct result.

Source files
------------

// File: rtl/log_antilog_mac_seq.sv
// Sequential log-domain MAC: per term, adds phi and weight logs, applies a Mitchell
// antilog and accumulates the signed products, one term per clock.
module log_antilog_mac_seq #(
    parameter int Q_ORD     = 7,
    parameter int WIDTH     = 16,
    parameter int QP        = 12,
    parameter int LOG_WIDTH = 17,
    parameter int ACC_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [Q_ORD*LOG_WIDTH-1:0]   phi_log_packed,
    input  logic [Q_ORD-1:0]             phi_sign_packed,
    input  logic [Q_ORD-1:0]             phi_valid_packed,
    input  logic [Q_ORD*LOG_WIDTH-1:0]   w_log_packed,
    input  logic [Q_ORD-1:0]             w_sign_packed,
    input  logic [Q_ORD-1:0]             w_valid_packed,
    output logic signed [WIDTH-1:0]      y_out,
    output logic                         out_valid,
    input  logic                         out_ready
);

    localparam int CNT_W = (Q_ORD > 1) ? $clog2(Q_ORD) : 1;
    localparam int S_W   = LOG_WIDTH + 1;
    localparam int EXP_W = S_W - QP;
    localparam int UP_W  = QP + 1 + (1 << (EXP_W - 1));
    localparam logic [CNT_W-1:0] LAST = CNT_W'(Q_ORD - 1);
    localparam logic [UP_W-1:0] MAG_MAX = UP_W'({(ACC_WIDTH-1){1'b1}});
    localparam logic signed [ACC_WIDTH-1:0] Y_MAX = ACC_WIDTH'({(WIDTH-1){1'b1}});
    localparam logic signed [ACC_WIDTH-1:0] Y_MIN = ~Y_MAX;

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
    state_t state, state_next;

    logic [Q_ORD*LOG_WIDTH-1:0] phi_log_r, w_log_r;
    logic [Q_ORD-1:0]           phi_sign_r, phi_valid_r, w_sign_r, w_valid_r;
    logic [CNT_W-1:0]           cnt;
    logic signed [ACC_WIDTH-1:0] acc;

    logic signed [LOG_WIDTH-1:0] phi_arr [Q_ORD];
    logic signed [LOG_WIDTH-1:0] w_arr   [Q_ORD];

    for (genvar g = 0; g < Q_ORD; g++) begin : g_unpack
        assign phi_arr[g] = phi_log_r[g*LOG_WIDTH +: LOG_WIDTH];
        assign w_arr[g]   = w_log_r[g*LOG_WIDTH +: LOG_WIDTH];
    end

    // Handshake: a frame transfers on an edge with in_valid && in_ready; a result
    // transfers on an edge with out_valid && out_ready. Neither side may retract early.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)    state_next = ACC;
            ACC:     if (cnt == LAST) state_next = DONE;
            DONE:    if (out_ready)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    logic signed [S_W-1:0]       s;
    logic signed [EXP_W-1:0]     e;
    logic [EXP_W-1:0]            ne;
    logic [QP:0]                 m;
    logic [UP_W-1:0]             up;
    logic [ACC_WIDTH-1:0]        mag;
    logic signed [ACC_WIDTH:0]   term;
    logic signed [ACC_WIDTH:0]   sum;
    logic signed [ACC_WIDTH-1:0] acc_next;
    logic signed [WIDTH-1:0]     y_sat;

    always_comb begin
        s  = {phi_arr[cnt][LOG_WIDTH-1], phi_arr[cnt]} + {w_arr[cnt][LOG_WIDTH-1], w_arr[cnt]};
        e  = s[S_W-1:QP];
        ne = -e;
        m  = {1'b1, s[QP-1:0]};
        up = '0;
        if (!e[EXP_W-1]) begin
            up  = UP_W'(m) << e;
            mag = (up > MAG_MAX) ? ACC_WIDTH'(MAG_MAX) : up[ACC_WIDTH-1:0];
        end else if (ne > EXP_W'(QP)) begin
            mag = '0;
        end else begin
            mag = ACC_WIDTH'(m >> ne);
        end
        if (!phi_valid_r[cnt] || !w_valid_r[cnt]) mag = '0;

        term = (phi_sign_r[cnt] ^ w_sign_r[cnt]) ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
        sum  = {acc[ACC_WIDTH-1], acc} + term;
        // Both operands fit ACC_WIDTH, so a top-two-bit disagreement is exactly overflow.
        if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1])
            acc_next = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        else
            acc_next = sum[ACC_WIDTH-1:0];

        if (acc_next > Y_MAX)      y_sat = Y_MAX[WIDTH-1:0];
        else if (acc_next < Y_MIN) y_sat = Y_MIN[WIDTH-1:0];
        else                       y_sat = acc_next[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            phi_log_r   <= '0;
            w_log_r     <= '0;
            phi_sign_r  <= '0;
            phi_valid_r <= '0;
            w_sign_r    <= '0;
            w_valid_r   <= '0;
            cnt         <= '0;
            acc         <= '0;
            y_out       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        phi_log_r   <= phi_log_packed;
                        w_log_r     <= w_log_packed;
                        phi_sign_r  <= phi_sign_packed;
                        phi_valid_r <= phi_valid_packed;
                        w_sign_r    <= w_sign_packed;
                        w_valid_r   <= w_valid_packed;
                        acc         <= '0;
                        cnt         <= '0;
                    end
                end
                ACC: begin
                    acc <= acc_next;
                    if (cnt == LAST) begin
                        y_out <= y_sat;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_log_antilog_mac_seq.sv
// Directed bench for log_antilog_mac_seq: hand-computed Mitchell products, saturation,
// backpressure and mid-frame reset.
module tb_log_antilog_mac_seq;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [7*17-1:0]    phi_log_packed;
    logic [6:0]         phi_sign_packed;
    logic [6:0]         phi_valid_packed;
    logic [7*17-1:0]    w_log_packed;
    logic [6:0]         w_sign_packed;
    logic [6:0]         w_valid_packed;
    logic signed [15:0] y_out;
    logic               out_valid;
    logic               out_ready;

    int checks = 0;
    int errors = 0;

    logic signed [16:0] pl [7];
    logic signed [16:0] wl [7];
    logic [6:0] ps, pv, ws, wv;

    log_antilog_mac_seq dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .phi_log_packed(phi_log_packed), .phi_sign_packed(phi_sign_packed),
        .phi_valid_packed(phi_valid_packed), .w_log_packed(w_log_packed),
        .w_sign_packed(w_sign_packed), .w_valid_packed(w_valid_packed),
        .y_out(y_out), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic defaults();
        for (int i = 0; i < 7; i++) begin
            pl[i] = '0;
            wl[i] = '0;
        end
        ps = '0; ws = '0; pv = '1; wv = '1;
    endtask

    task automatic apply_frame();
        for (int i = 0; i < 7; i++) begin
            phi_log_packed[i*17 +: 17] = pl[i];
            w_log_packed[i*17 +: 17]   = wl[i];
        end
        phi_sign_packed = ps; w_sign_packed = ws;
        phi_valid_packed = pv; w_valid_packed = wv;
    endtask

    // Presents a frame, waits for acceptance, returns edges from accept to out_valid (-1 on timeout).
    task automatic run_frame(output int lat);
        int k;
        apply_frame();
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = -1;
        for (int j = 1; j <= 20; j++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = j;
                break;
            end
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (y_out !== 16'sd0) begin errors++; $display("FAIL reset_y: got %0d expected 0", y_out); end
    endtask

    task automatic test_unity_sum();
        int lat;
        defaults();
        run_frame(lat);
        checks++; if (lat !== 7) begin errors++; $display("FAIL unity_latency: got %0d expected 7", lat); end
        checks++; if (int'(y_out) !== 28672) begin errors++; $display("FAIL unity_y: got %0d expected 28672", y_out); end
        release_out();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL unity_handshake: got out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready); end
        checks++; if (int'(y_out) !== 28672) begin errors++; $display("FAIL unity_hold: got %0d expected 28672", y_out); end
    endtask

    task automatic test_sign_mix();
        int lat;
        defaults();
        ps = 7'b0101010;
        run_frame(lat);
        checks++; if (int'(y_out) !== 4096 || lat !== 7) begin errors++; $display("FAIL sign_mix: got y=%0d lat=%0d expected 4096 7", y_out, lat); end
        release_out();
    endtask

    task automatic test_single_term();
        int lat;
        int logs [6] = '{-4096, 2048, -2048, -49152, -53248, 0};
        int exps [6] = '{2048, 6144, 3072, 1, 0, 0};
        for (int t = 0; t < 6; t++) begin
            defaults();
            pv = 7'b0000001;
            pl[0] = 17'(logs[t]);
            if (t == 5) begin
                pl[0] = 17'sd2048;
                wv = 7'b1111110;
            end
            run_frame(lat);
            checks++;
            if (int'(y_out) !== exps[t] || lat !== 7) begin
                errors++;
                $display("FAIL single_term_%0d: got y=%0d lat=%0d expected %0d 7", t, y_out, lat, exps[t]);
            end
            release_out();
        end
    endtask

    task automatic test_saturation();
        int lat;
        defaults();
        for (int i = 0; i < 7; i++) pl[i] = 17'sd8192;
        run_frame(lat);
        checks++; if (int'(y_out) !== 32767) begin errors++; $display("FAIL sat_pos: got %0d expected 32767", y_out); end
        release_out();
        ps = '1;
        run_frame(lat);
        checks++; if (int'(y_out) !== -32768) begin errors++; $display("FAIL sat_neg: got %0d expected -32768", y_out); end
        release_out();
    endtask

    task automatic test_backpressure();
        int lat;
        defaults();
        run_frame(lat);
        checks++; if (int'(y_out) !== 28672) begin errors++; $display("FAIL bp_first: got %0d expected 28672", y_out); end
        for (int i = 0; i < 7; i++) wl[i] = -17'sd4096;
        apply_frame();
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || int'(y_out) !== 28672) begin
                errors++;
                $display("FAIL bp_hold_%0d: got out_valid=%b in_ready=%b y=%0d expected 1 0 28672", c, out_valid, in_ready, y_out);
            end
        end
        release_out();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_idle: got out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_accept: got in_ready=%b expected 0", in_ready); end
        lat = -1;
        for (int j = 1; j <= 20; j++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = j;
                break;
            end
        end
        checks++; if (int'(y_out) !== 14336 || lat !== 7) begin errors++; $display("FAIL bp_second: got y=%0d lat=%0d expected 14336 7", y_out, lat); end
        release_out();
    endtask

    task automatic test_mid_frame_reset();
        int lat;
        defaults();
        apply_frame();
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || y_out !== 16'sd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: got out_valid=%b y=%0d in_ready=%b expected 0 0 1", out_valid, y_out, in_ready);
        end
        for (int i = 0; i < 7; i++) pl[i] = -17'sd2048;
        run_frame(lat);
        checks++; if (int'(y_out) !== 21504 || lat !== 7) begin errors++; $display("FAIL post_reset_frame: got y=%0d lat=%0d expected 21504 7", y_out, lat); end
        release_out();
    endtask

    initial begin
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        defaults();
        apply_frame();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        test_unity_sum();
        test_sign_mix();
        test_single_term();
        test_saturation();
        test_backpressure();
        test_mid_frame_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
